ps2_scancode_decoder: RTL and testbench

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

---
 rtl/ps2_pkg.sv | 54 +++++
 rtl/ps2_event_fifo.sv | 70 +++++++
 rtl/ps2_scancode_decoder.sv | 140 ++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, parser state and event types for the PS/2 scancode decoder.
// Covers the prefix bytes, the keyboard responses that never become events, and the arrow keys.
package ps2_pkg;

    localparam logic [7:0] SC_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] SC_PREFIX_BRK = 8'hF0;

    // Keyboard responses that are not key events when seen outside a prefix sequence
    localparam logic [7:0] SC_BAT_OK  = 8'hAA;
    localparam logic [7:0] SC_ACK     = 8'hFA;
    localparam logic [7:0] SC_ECHO    = 8'hEE;
    localparam logic [7:0] SC_BAT_ERR = 8'hFC;
    localparam logic [7:0] SC_RESEND  = 8'hFE;
    localparam logic [7:0] SC_ERR0    = 8'h00;

    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_UP    = 8'h75;

    localparam int EVENT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    function automatic logic is_ignored(input logic [7:0] b);
        return b inside {SC_BAT_OK, SC_ACK, SC_ECHO, SC_BAT_ERR, SC_RESEND, SC_ERR0};
    endfunction

    // One-hot position in the arrows vector {up, down, right, left}; zero for any other code.
    function automatic logic [3:0] arrow_mask(input logic [7:0] code);
        logic [3:0] m;
        m = 4'b0000;
        case (code)
            SC_LEFT:  m = 4'b0001;
            SC_RIGHT: m = 4'b0010;
            SC_DOWN:  m = 4'b0100;
            SC_UP:    m = 4'b1000;
            default:  m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead event FIFO: the head entry is presented combinationally while not empty.
// Pushing when full is only accepted if the head is popped in the same cycle.
module ps2_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign head_data = mem_q[rd_ptr_q];
    assign pop_ok    = pop & ~empty;
    assign push_ok   = push & (~full | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: empty gates everything read from it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode parser: strips E0/F0 prefixes, queues key events and tracks held arrow keys.
// state      | meaning
// ST_IDLE    | no prefix pending
// ST_EXT     | E0 seen
// ST_BRK     | F0 seen
// ST_EXT_BRK | E0 then F0 seen
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_byte_en,
    output logic       event_valid,
    input  logic       event_ready,
    output logic [7:0] event_code,
    output logic       event_ext,
    output logic       event_break,
    output logic       event_overflow,
    output logic [3:0] arrows
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       arrows_q, arrows_d;
    logic             overflow_q, overflow_d;
    logic             push;
    ps2_event_t       push_evt;
    ps2_event_t       head_evt;
    logic             fifo_full;
    logic             fifo_empty;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        push     = 1'b0;
        push_evt = '0;
        if (ps2_byte_en) begin
            cnt_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (ps2_byte == SC_PREFIX_EXT) begin
                        state_d = ST_EXT;
                    end else if (ps2_byte == SC_PREFIX_BRK) begin
                        state_d = ST_BRK;
                    end else if (!is_ignored(ps2_byte)) begin
                        push     = 1'b1;
                        push_evt = '{ext: 1'b0, brk: 1'b0, code: ps2_byte};
                    end
                end
                ST_EXT: begin
                    if (ps2_byte == SC_PREFIX_EXT) begin
                        state_d = ST_EXT;
                    end else if (ps2_byte == SC_PREFIX_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        push     = 1'b1;
                        push_evt = '{ext: 1'b1, brk: 1'b0, code: ps2_byte};
                        state_d  = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    // A new prefix mid-break restarts the sequence rather than completing it
                    if (ps2_byte == SC_PREFIX_EXT) begin
                        state_d = ST_EXT;
                    end else if (ps2_byte == SC_PREFIX_BRK) begin
                        state_d = ST_BRK;
                    end else begin
                        push     = 1'b1;
                        push_evt = '{ext: (state_q == ST_EXT_BRK), brk: 1'b1, code: ps2_byte};
                        state_d  = ST_IDLE;
                    end
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Arrow state follows the parser even when the event itself is dropped
    always_comb begin
        arrows_d = arrows_q;
        if (push && push_evt.ext) begin
            if (push_evt.brk) begin
                arrows_d = arrows_q & ~arrow_mask(push_evt.code);
            end else begin
                arrows_d = arrows_q | arrow_mask(push_evt.code);
            end
        end
    end

    assign overflow_d = overflow_q | (push & fifo_full & ~(event_ready & ~fifo_empty));

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            arrows_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            arrows_q   <= arrows_d;
            overflow_q <= overflow_d;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVENT_W)
    ) u_fifo (
        .clk       (CLOCK_50),
        .rst       (reset),
        .push      (push),
        .push_data (push_evt),
        .pop       (event_ready),
        .head_data (head_evt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign event_valid    = ~fifo_empty;
    assign event_code     = fifo_empty ? 8'h00 : head_evt.code;
    assign event_ext      = ~fifo_empty & head_evt.ext;
    assign event_break    = ~fifo_empty & head_evt.brk;
    assign event_overflow = overflow_q;
    assign arrows         = arrows_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: directed scenarios plus a randomized byte stream
// compared cycle by cycle against a prefix-flag / event-queue reference model.
module tb_ps2_scancode_decoder;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [7:0] ps2_byte;
    logic       ps2_byte_en;
    logic       event_valid;
    logic       event_ready;
    logic [7:0] event_code;
    logic       event_ext;
    logic       event_break;
    logic       event_overflow;
    logic [3:0] arrows;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending prefix flags, quiet-cycle count, expected FIFO contents
    bit         m_pend, m_pext, m_pbrk;
    int         m_gap;
    logic [9:0] m_q[$];
    logic [3:0] m_arrows;
    bit         m_ovf;

    logic [15:0] dut_out;

    ps2_scancode_decoder #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .ps2_byte       (ps2_byte),
        .ps2_byte_en    (ps2_byte_en),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_code     (event_code),
        .event_ext      (event_ext),
        .event_break    (event_break),
        .event_overflow (event_overflow),
        .arrows         (arrows)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    assign dut_out = {event_valid, event_ext, event_break, event_code, event_overflow, arrows};

    function automatic bit model_ignored(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) || (b == 8'hFC) ||
               (b == 8'hFE) || (b == 8'h00);
    endfunction

    function automatic logic [15:0] model_out();
        logic [9:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 10'h000;
        return {(m_q.size() > 0) ? 1'b1 : 1'b0, h, m_ovf ? 1'b1 : 1'b0, m_arrows};
    endfunction

    task automatic model_clear();
        m_pend = 0; m_pext = 0; m_pbrk = 0; m_gap = 0;
        m_q.delete();
        m_arrows = 4'b0000;
        m_ovf = 0;
    endtask

    task automatic model_update(input bit en, input logic [7:0] b, input bit rdy);
        bit         emit;
        logic [9:0] ev;
        int         idx;
        emit = 0;
        ev   = '0;
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (en) begin
            m_gap = 0;
            if (b == 8'hE0) begin
                m_pend = 1; m_pext = 1; m_pbrk = 0;
            end else if (b == 8'hF0) begin
                m_pext = m_pend && m_pext && !m_pbrk;
                m_pbrk = 1; m_pend = 1;
            end else if (!m_pend && model_ignored(b)) begin
                emit = 0;
            end else begin
                emit = 1;
                ev   = {m_pext, m_pbrk, b};
                m_pend = 0; m_pext = 0; m_pbrk = 0;
            end
        end else if (m_pend) begin
            m_gap++;
            if (m_gap >= TIMEOUT) begin
                m_pend = 0; m_pext = 0; m_pbrk = 0; m_gap = 0;
            end
        end
        if (emit) begin
            if (m_q.size() < DEPTH) m_q.push_back(ev);
            else m_ovf = 1;
            if (ev[9]) begin
                idx = (b == 8'h6B) ? 0 : (b == 8'h74) ? 1 : (b == 8'h72) ? 2 : (b == 8'h75) ? 3 : -1;
                if (idx >= 0) m_arrows[idx] = ~ev[8];
            end
        end
    endtask

    // Called at a falling edge; applies inputs across one rising edge and returns at the next falling edge.
    task automatic step(input bit en, input logic [7:0] b, input bit rdy);
        ps2_byte_en = en;
        ps2_byte    = b;
        event_ready = rdy;
        @(negedge CLOCK_50);
        model_update(en, b, rdy);
        ps2_byte_en = 1'b0;
        event_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ps2_byte_en = 1'b0; ps2_byte = 8'h00; event_ready = 1'b0;
        model_clear();
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (dut_out !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_state: got %h expected 0000", dut_out);
        end
    endtask

    task automatic test_arrows();
        do_reset();
        step(1, 8'hE0, 0);
        step(1, 8'h6B, 0);
        n_vec++;
        if (dut_out !== {1'b1, 1'b1, 1'b0, 8'h6B, 1'b0, 4'b0001}) begin
            n_err++;
            $display("FAIL ext_make_left: got %h expected %h", dut_out, {1'b1, 1'b1, 1'b0, 8'h6B, 1'b0, 4'b0001});
        end
        step(0, 8'h00, 1);
        step(1, 8'hE0, 0);
        step(1, 8'hF0, 0);
        step(1, 8'h6B, 0);
        n_vec++;
        if (dut_out !== {1'b1, 1'b1, 1'b1, 8'h6B, 1'b0, 4'b0000}) begin
            n_err++;
            $display("FAIL ext_break_left: got %h expected %h", dut_out, {1'b1, 1'b1, 1'b1, 8'h6B, 1'b0, 4'b0000});
        end
        step(0, 8'h00, 1);
        step(1, 8'hE0, 0);
        step(1, 8'h72, 0);
        step(1, 8'hE0, 0);
        step(1, 8'h72, 0);
        step(1, 8'h72, 0);
        n_vec++;
        if (arrows !== 4'b0100 || m_q.size() != 3 || dut_out !== model_out()) begin
            n_err++;
            $display("FAIL typematic_down: got %h expected %h", dut_out, model_out());
        end
    endtask

    task automatic test_make_break();
        do_reset();
        step(1, 8'h1C, 0);
        step(1, 8'hF0, 0);
        step(1, 8'h1C, 0);
        n_vec++;
        if (dut_out !== {1'b1, 1'b0, 1'b0, 8'h1C, 1'b0, 4'b0000}) begin
            n_err++;
            $display("FAIL make_1c: got %h expected %h", dut_out, {1'b1, 1'b0, 1'b0, 8'h1C, 1'b0, 4'b0000});
        end
        step(0, 8'h00, 1);
        n_vec++;
        if (dut_out !== {1'b1, 1'b0, 1'b1, 8'h1C, 1'b0, 4'b0000}) begin
            n_err++;
            $display("FAIL break_1c: got %h expected %h", dut_out, {1'b1, 1'b0, 1'b1, 8'h1C, 1'b0, 4'b0000});
        end
        step(0, 8'h00, 1);
        step(1, 8'hAA, 0);
        step(1, 8'h00, 0);
        n_vec++;
        if (dut_out !== 16'h0000) begin
            n_err++;
            $display("FAIL ignored_aa: got %h expected 0000", dut_out);
        end
        step(1, 8'hF0, 0);
        step(1, 8'hAA, 0);
        n_vec++;
        if (dut_out !== {1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 4'b0000}) begin
            n_err++;
            $display("FAIL break_aa: got %h expected %h", dut_out, {1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 4'b0000});
        end
    endtask

    task automatic test_timeout();
        do_reset();
        step(1, 8'hE0, 0);
        for (int i = 0; i < TIMEOUT; i++) step(0, 8'h00, 0);
        step(1, 8'h75, 0);
        n_vec++;
        if (dut_out !== {1'b1, 1'b0, 1'b0, 8'h75, 1'b0, 4'b0000}) begin
            n_err++;
            $display("FAIL timeout_16: got %h expected %h", dut_out, {1'b1, 1'b0, 1'b0, 8'h75, 1'b0, 4'b0000});
        end
        step(0, 8'h00, 1);
        step(1, 8'hE0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(0, 8'h00, 0);
        step(1, 8'h75, 0);
        n_vec++;
        if (dut_out !== {1'b1, 1'b1, 1'b0, 8'h75, 1'b0, 4'b1000}) begin
            n_err++;
            $display("FAIL no_timeout_15: got %h expected %h", dut_out, {1'b1, 1'b1, 1'b0, 8'h75, 1'b0, 4'b1000});
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_codes[4];
        exp_codes = '{8'h1D, 8'h24, 8'h2D, 8'h3C};
        do_reset();
        step(1, 8'h15, 0);
        step(1, 8'h1D, 0);
        step(1, 8'h24, 0);
        step(1, 8'h2D, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0);
        n_vec++;
        if (dut_out !== {1'b1, 1'b0, 1'b0, 8'h15, 1'b0, 4'b0000}) begin
            n_err++;
            $display("FAIL full_stable_head: got %h expected %h", dut_out, {1'b1, 1'b0, 1'b0, 8'h15, 1'b0, 4'b0000});
        end
        step(1, 8'h3C, 1);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (event_valid !== 1'b1 || event_code !== exp_codes[i] || event_overflow !== 1'b0) begin
                n_err++;
                $display("FAIL full_pushpop_drain%0d: got v=%b code=%h ovf=%b expected v=1 code=%h ovf=0",
                         i, event_valid, event_code, event_overflow, exp_codes[i]);
            end
            step(0, 8'h00, 1);
        end
        n_vec++;
        if (event_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_pushpop_empty: got valid=%b expected 0", event_valid);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] codes[5];
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        do_reset();
        for (int i = 0; i < 5; i++) step(1, codes[i], 0);
        n_vec++;
        if (event_overflow !== 1'b1 || event_code !== 8'h15) begin
            n_err++;
            $display("FAIL overflow_flag: got ovf=%b code=%h expected ovf=1 code=15", event_overflow, event_code);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (event_valid !== 1'b1 || event_code !== codes[i]) begin
                n_err++;
                $display("FAIL overflow_drain%0d: got v=%b code=%h expected v=1 code=%h",
                         i, event_valid, event_code, codes[i]);
            end
            step(0, 8'h00, 1);
        end
        step(0, 8'h00, 1);
        n_vec++;
        if (dut_out !== {1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'b0000}) begin
            n_err++;
            $display("FAIL overflow_sticky_empty: got %h expected %h", dut_out, {1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'b0000});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1, 8'hE0, 0);
        step(1, 8'h75, 0);
        step(1, 8'hE0, 0);
        step(1, 8'hF0, 0);
        do_reset();
        n_vec++;
        if (dut_out !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_mid_state: got %h expected 0000", dut_out);
        end
        step(1, 8'h74, 0);
        n_vec++;
        if (dut_out !== {1'b1, 1'b0, 1'b0, 8'h74, 1'b0, 4'b0000}) begin
            n_err++;
            $display("FAIL reset_mid_74: got %h expected %h", dut_out, {1'b1, 1'b0, 1'b0, 8'h74, 1'b0, 4'b0000});
        end
    endtask

    task automatic test_random();
        logic [7:0] pool[10];
        logic [7:0] b;
        bit         en, rdy;
        int         gap;
        pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h72, 8'h75, 8'h1C, 8'hAA, 8'h00, 8'hFA};
        do_reset();
        for (int c = 0; c < 800; c++) begin
            gap = ($urandom_range(0, 19) == 0) ? int'($urandom_range(10, 20)) : 1;
            for (int g = 0; g < gap; g++) begin
                en  = (gap == 1) && ($urandom_range(0, 9) < 5);
                b   = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 9)];
                rdy = ($urandom_range(0, 9) < 4);
                step(en, b, rdy);
                n_vec++;
                if (dut_out !== model_out()) begin
                    n_err++;
                    $display("FAIL random_cycle%0d: got %h expected %h", c, dut_out, model_out());
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        ps2_byte = 8'h00;
        ps2_byte_en = 1'b0;
        event_ready = 1'b0;
        model_clear();
        @(negedge CLOCK_50);
        test_reset();
        test_arrows();
        test_make_break();
        test_timeout();
        test_full_push_pop();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
